// File: rtl/sm_addsub_pkg.sv
// Shared types and constants for the sign-magnitude add/sub unit.
// Optional feature macro (used by sm_addsub_unit): SM_ADDSUB_SAT_EN.
package sm_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        EXEC = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/sm_addsub_unit_core.sv
// Combinational magnitude datapath: compare plus add / larger-minus-smaller.
// The subtract path uses the registered compare result, so it never borrows.
module sm_mag_core #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] i_a_mag,
    input  logic [WIDTH-1:0] i_b_mag,
    input  logic             i_sub,
    input  logic             i_a_ge_b,
    output logic             o_a_ge_b,
    output logic [WIDTH-1:0] o_mag,
    output logic             o_carry
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;

    // Compare, sum and ordered difference, then select by effective operation
    always_comb begin
        o_a_ge_b = (i_a_mag >= i_b_mag);
        w_sum    = {1'b0, i_a_mag} + {1'b0, i_b_mag};
        w_diff   = i_a_ge_b ? (i_a_mag - i_b_mag) : (i_b_mag - i_a_mag);
        o_mag    = w_sum[WIDTH-1:0];
        o_carry  = w_sum[WIDTH];
        if (i_sub) begin
            o_mag   = w_diff;
            o_carry = 1'b0;
        end
    end

endmodule

// File: rtl/sm_addsub_unit.sv
// Sign-magnitude adder/subtractor with valid/ready on both sides.
// Optional macro SM_ADDSUB_SAT_EN: effective-add overflow saturates the
// magnitude to all ones and raises o_sat; otherwise the magnitude wraps.
//
// state | meaning
// IDLE  | waiting for an operand set; o_in_ready high when enabled
// CMP   | derive effective B sign / operation, register a >= b
// EXEC  | compute result, load output registers, raise o_out_valid
// DONE  | hold result until consumer takes it
module sm_addsub_unit
    import sm_addsub_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic             i_op,
    input  logic             i_a_sign,
    input  logic             i_b_sign,
    input  logic [WIDTH-1:0] i_a_mag,
    input  logic [WIDTH-1:0] i_b_mag,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_res_sign,
    output logic [WIDTH-1:0] o_res_mag,
    output logic             o_c_out,
    output logic             o_zero,
    output logic             o_sat
);

    state_t           r_state;
    state_t           w_next_state;

    logic             r_a_sign;
    logic             r_b_sign;
    logic [WIDTH-1:0] r_a_mag;
    logic [WIDTH-1:0] r_b_mag;
    logic             r_op;
    logic             r_eb;
    logic             r_sub;
    logic             r_a_ge_b;

    logic             r_out_valid;
    logic             r_res_sign;
    logic [WIDTH-1:0] r_res_mag;
    logic             r_c_out;
    logic             r_zero;
    logic             r_sat;

    logic             w_a_ge_b;
    logic [WIDTH-1:0] w_core_mag;
    logic             w_core_carry;
    logic             w_eb;
    logic [WIDTH-1:0] w_mag_next;
    logic             w_c_next;
    logic             w_sat_next;
    logic             w_zero_next;
    logic             w_sign_next;

    sm_mag_core #(.WIDTH(WIDTH)) u_core (
        .i_a_mag  (r_a_mag),
        .i_b_mag  (r_b_mag),
        .i_sub    (r_sub),
        .i_a_ge_b (r_a_ge_b),
        .o_a_ge_b (w_a_ge_b),
        .o_mag    (w_core_mag),
        .o_carry  (w_core_carry)
    );

    assign o_in_ready  = i_en & (r_state == IDLE);
    assign o_out_valid = r_out_valid;
    assign o_res_sign  = r_res_sign;
    assign o_res_mag   = r_res_mag;
    assign o_c_out     = r_c_out;
    assign o_zero      = r_zero;
    assign o_sat       = r_sat;

    assign w_eb = r_b_sign ^ (r_op == OP_SUB);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic; a low enable holds the current state
    always_comb begin
        w_next_state = r_state;
        if (i_en) begin
            case (r_state)
                IDLE:    if (i_in_valid)  w_next_state = CMP;
                CMP:     w_next_state = EXEC;
                EXEC:    w_next_state = DONE;
                DONE:    if (i_out_ready) w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Result value, status and sign for the EXEC->DONE load; never negative zero
    always_comb begin
        w_c_next   = ~r_sub & w_core_carry;
        w_mag_next = w_core_mag;
        w_sat_next = 1'b0;
`ifdef SM_ADDSUB_SAT_EN
        if (w_c_next) begin
            w_mag_next = '1;
            w_sat_next = 1'b1;
        end
`endif
        w_zero_next = (w_mag_next == '0);
        w_sign_next = r_sub ? (r_a_ge_b ? r_a_sign : r_eb) : r_a_sign;
        if (w_zero_next) w_sign_next = 1'b0;
    end

    // Operand capture, compare staging and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sign    <= 1'b0;
            r_b_sign    <= 1'b0;
            r_a_mag     <= '0;
            r_b_mag     <= '0;
            r_op        <= OP_ADD;
            r_eb        <= 1'b0;
            r_sub       <= 1'b0;
            r_a_ge_b    <= 1'b0;
            r_out_valid <= 1'b0;
            r_res_sign  <= 1'b0;
            r_res_mag   <= '0;
            r_c_out     <= 1'b0;
            r_zero      <= 1'b0;
            r_sat       <= 1'b0;
        end else if (i_en) begin
            case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_a_sign <= i_a_sign;
                        r_b_sign <= i_b_sign;
                        r_a_mag  <= i_a_mag;
                        r_b_mag  <= i_b_mag;
                        r_op     <= i_op;
                    end
                end
                CMP: begin
                    r_eb     <= w_eb;
                    r_sub    <= (r_a_sign != w_eb);
                    r_a_ge_b <= w_a_ge_b;
                end
                EXEC: begin
                    r_res_mag   <= w_mag_next;
                    r_res_sign  <= w_sign_next;
                    r_c_out     <= w_c_next;
                    r_zero      <= w_zero_next;
                    r_sat       <= w_sat_next;
                    r_out_valid <= 1'b1;
                end
                DONE: begin
                    if (i_out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_addsub_unit.sv
// Directed-vector bench for sm_addsub_unit (WIDTH = 24).
module tb_sm_addsub_unit;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic         a_sign;
    logic         b_sign;
    logic [W-1:0] a_mag;
    logic [W-1:0] b_mag;
    logic         out_valid;
    logic         out_ready;
    logic         res_sign;
    logic [W-1:0] res_mag;
    logic         c_out;
    logic         zero;
    logic         sat;

    int n_cmp = 0;
    int n_bad = 0;

    sm_addsub_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_en        (en),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_op        (op),
        .i_a_sign    (a_sign),
        .i_b_sign    (b_sign),
        .i_a_mag     (a_mag),
        .i_b_mag     (b_mag),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_res_sign  (res_sign),
        .o_res_mag   (res_mag),
        .o_c_out     (c_out),
        .o_zero      (zero),
        .o_sat       (sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic s, input logic [W-1:0] m,
                           input logic c, input logic z, input logic st);
        chk({tag, ".sign"}, {31'd0, res_sign}, {31'd0, s});
        chk({tag, ".mag"},  {8'd0, res_mag},   {8'd0, m});
        chk({tag, ".cout"}, {31'd0, c_out},    {31'd0, c});
        chk({tag, ".zero"}, {31'd0, zero},     {31'd0, z});
        chk({tag, ".sat"},  {31'd0, sat},      {31'd0, st});
    endtask

    // Capture at edge N, expect out_valid low after N and N+1, high after N+2.
    task automatic issue(input string tag, input logic as, input logic [W-1:0] am,
                         input logic o, input logic bs, input logic [W-1:0] bm);
        @(negedge clk);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        a_sign = as; a_mag = am; op = o; b_sign = bs; b_mag = bm;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".ov_n0"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk({tag, ".ov_n1"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk({tag, ".ov_n2"}, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".ov_clr"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".in_rdy"}, {31'd0, in_ready},  32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; op = 1'b0; out_ready = 1'b0;
        a_sign = 1'b0; b_sign = 1'b0; a_mag = '0; b_mag = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst.ov",       {31'd0, out_valid}, 32'd0);
        chk("rst.in_ready", {31'd0, in_ready},  32'd1);
        chk_res("rst", 1'b0, 24'd0, 1'b0, 1'b0, 1'b0);

        issue("add53", 1'b0, 24'd5, 1'b0, 1'b0, 24'd3);
        chk_res("add53", 1'b0, 24'd8, 1'b0, 1'b0, 1'b0);
        consume("add53");

        issue("sub35", 1'b0, 24'd3, 1'b1, 1'b0, 24'd5);
        chk_res("sub35", 1'b1, 24'd2, 1'b0, 1'b0, 1'b0);
        consume("sub35");

        issue("m7p7", 1'b1, 24'd7, 1'b0, 1'b0, 24'd7);
        chk_res("m7p7", 1'b0, 24'd0, 1'b0, 1'b1, 1'b0);
        consume("m7p7");

        issue("ovf", 1'b0, 24'hFFFFFF, 1'b0, 1'b0, 24'd1);
`ifdef SM_ADDSUB_SAT_EN
        chk_res("ovf", 1'b0, 24'hFFFFFF, 1'b1, 1'b0, 1'b1);
`else
        chk_res("ovf", 1'b0, 24'd0, 1'b1, 1'b1, 1'b0);
`endif
        consume("ovf");

        issue("m3m4", 1'b1, 24'd3, 1'b0, 1'b1, 24'd4);
        chk_res("m3m4", 1'b1, 24'd7, 1'b0, 1'b0, 1'b0);
        consume("m3m4");

        // Backpressure: result held, in_ready low for 5 cycles.
        issue("bp", 1'b1, 24'd10, 1'b1, 1'b1, 24'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.ov_hold", {31'd0, out_valid}, 32'd1);
            chk("bp.in_rdy0", {31'd0, in_ready},  32'd0);
            chk_res("bp.hold", 1'b1, 24'd6, 1'b0, 1'b0, 1'b0);
        end
        // Enable low freezes DONE even with out_ready high.
        en = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("en0.ov",       {31'd0, out_valid}, 32'd1);
        chk("en0.in_ready", {31'd0, in_ready},  32'd0);
        en = 1'b1;
        consume("bp");

        // Reset while in EXEC discards the operation and clears outputs.
        @(negedge clk);
        a_sign = 1'b0; a_mag = 24'd9; op = 1'b0; b_sign = 1'b0; b_mag = 24'd9;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstx.ov",       {31'd0, out_valid}, 32'd0);
        chk("rstx.in_ready", {31'd0, in_ready},  32'd1);
        chk_res("rstx", 1'b0, 24'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rstx.ov_later", {31'd0, out_valid}, 32'd0);

        issue("p1p1", 1'b0, 24'd1, 1'b0, 1'b0, 24'd1);
        chk_res("p1p1", 1'b0, 24'd2, 1'b0, 1'b0, 1'b0);
        consume("p1p1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
